// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Desc     : Port indices and XY route compute shared by the mesh router.
// Revision : 1.0
// ============================================================================
package router_pkg;

    localparam int NPORTS = 5;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_E = 3'd1;
    localparam logic [2:0] PORT_S = 3'd2;
    localparam logic [2:0] PORT_W = 3'd3;
    localparam logic [2:0] PORT_L = 3'd4;

    // Column first, then row; a flit already at its cell goes to the local port.
    function automatic logic [2:0] route_xy(input int dst_row, input int dst_col,
                                            input int cur_row, input int cur_col);
        logic [2:0] port;
        if (dst_col > cur_col)      port = PORT_E;
        else if (dst_col < cur_col) port = PORT_W;
        else if (dst_row > cur_row) port = PORT_S;
        else if (dst_row < cur_row) port = PORT_N;
        else                        port = PORT_L;
        return port;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// ============================================================================
// Module   : router_fifo
// Desc     : Per-input flit buffer with registered occupancy and show-ahead head.
// Revision : 1.0
// ============================================================================
module router_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        // Power-of-two depth lets the pointers wrap naturally.
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mesh_router_xy.sv
`default_nettype none
// ============================================================================
// Module   : mesh_router_xy
// Desc     : 5-port XY mesh router, input FIFOs, round-robin output stages.
//            Optional counters enabled by ROUTER_STATS_EN.
// Revision : 1.0
// ============================================================================
module mesh_router_xy #(
    parameter int FLIT_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int R          = 0,
    parameter int C          = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W*5-1:0] flit_in_flat,
    input  logic [4:0]        valid_in_flat,
    output logic [4:0]        ready_out_flat,
    output logic [FLIT_W*5-1:0] flit_out_flat,
    output logic [4:0]        valid_out_flat,
    input  logic [4:0]        ready_in_flat
`ifdef ROUTER_STATS_EN
    ,
    output logic [15:0]       drop_cnt,
    output logic [32*5-1:0]   fwd_cnt_flat
`endif
);
    import router_pkg::*;

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [NPORTS-1:0] ON_MESH = {1'b1, (C != 0), (R != ROWS-1), (C != COLS-1), (R != 0)};

    logic [FLIT_W-1:0] head [NPORTS];
    logic [NPORTS-1:0] full, empty, push, pop, drop, live;
    logic [2:0]        route [NPORTS];
    logic              rdy_en_q;
    logic [NPORTS-1:0] vld_q, vld_d;
    logic [2:0]        ptr_q [NPORTS];
    logic [2:0]        ptr_d [NPORTS];
    logic [FLIT_W-1:0] data_q [NPORTS];
    logic [FLIT_W-1:0] data_d [NPORTS];
    logic              gnt_any;
    logic [2:0]        gnt_idx;
    int                dst_row, dst_col, idx;

    // rdy_en_q keeps ready low until the first edge after reset releases.
    assign ready_out_flat = ON_MESH & ~full & {NPORTS{rdy_en_q}};
    assign push           = valid_in_flat & ready_out_flat;
    assign valid_out_flat = vld_q;

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        router_fifo #(.WIDTH(FLIT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[i]),
            .push_data (flit_in_flat[i*FLIT_W +: FLIT_W]),
            .pop       (pop[i]),
            .head_data (head[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );
        assign flit_out_flat[i*FLIT_W +: FLIT_W] = data_q[i];
    end

    always_comb begin
        drop    = '0;
        live    = '0;
        pop     = '0;
        route   = '{default: PORT_L};
        vld_d   = vld_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        gnt_any = 1'b0;
        gnt_idx = '0;
        dst_row = 0;
        dst_col = 0;
        idx     = 0;
        for (int i = 0; i < NPORTS; i++) begin
            dst_row  = int'(head[i][FLIT_W-1 -: ROW_W]);
            dst_col  = int'(head[i][FLIT_W-1-ROW_W -: COL_W]);
            route[i] = route_xy(dst_row, dst_col, R, C);
            if (!empty[i]) begin
                if (dst_row >= ROWS || dst_col >= COLS ||
                    (route[i] == 3'(i) && i != int'(PORT_L))) begin
                    drop[i] = 1'b1;
                end else begin
                    live[i] = 1'b1;
                end
            end
        end
        pop = drop;
        for (int o = 0; o < NPORTS; o++) begin
            gnt_any = 1'b0;
            gnt_idx = '0;
            // Search starts one past the input granted last on this output.
            for (int k = 1; k <= NPORTS; k++) begin
                idx = (int'(ptr_q[o]) + k) % NPORTS;
                if (!gnt_any && live[idx] && route[idx] == 3'(o)) begin
                    gnt_any = 1'b1;
                    gnt_idx = 3'(idx);
                end
            end
            if (!vld_q[o] || ready_in_flat[o]) begin
                vld_d[o] = gnt_any;
                if (gnt_any) begin
                    ptr_d[o]     = gnt_idx;
                    data_d[o]    = head[gnt_idx];
                    pop[gnt_idx] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en_q <= 1'b0;
            vld_q    <= '0;
            for (int o = 0; o < NPORTS; o++) begin
                ptr_q[o]  <= '0;
                data_q[o] <= '0;
            end
        end else begin
            rdy_en_q <= 1'b1;
            vld_q    <= vld_d;
            ptr_q    <= ptr_d;
            data_q   <= data_d;
        end
    end

`ifdef ROUTER_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;
    logic [31:0] fwd_cnt_q [NPORTS];
    logic [31:0] fwd_cnt_d [NPORTS];

    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < NPORTS; i++) begin
            drop_sum = drop_sum + 17'(drop[i]);
        end
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        for (int o = 0; o < NPORTS; o++) begin
            fwd_cnt_d[o] = fwd_cnt_q[o] + 32'(vld_q[o] && ready_in_flat[o]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
            for (int o = 0; o < NPORTS; o++) begin
                fwd_cnt_q[o] <= '0;
            end
        end else begin
            drop_cnt_q <= drop_cnt_d;
            fwd_cnt_q  <= fwd_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    for (genvar o = 0; o < NPORTS; o++) begin : g_fwd
        assign fwd_cnt_flat[o*32 +: 32] = fwd_cnt_q[o];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mesh_router_xy.sv
`default_nettype none
// ============================================================================
// Module   : tb_mesh_router_xy
// Desc     : Self-checking bench: 2x2 corner cell (u_dut) and 3x3 centre cell (u_ctr).
// Revision : 1.0
// ============================================================================
module tb_mesh_router_xy;

    localparam int FW    = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [FW*5-1:0] a_fin, a_fout, b_fin, b_fout;
    logic [4:0]      a_vin, a_rdy, a_vout, a_rin;
    logic [4:0]      b_vin, b_rdy, b_vout, b_rin;
`ifdef ROUTER_STATS_EN
    logic [15:0]     a_drop, b_drop;
    logic [159:0]    a_fwd, b_fwd;
`endif

    mesh_router_xy #(.FLIT_W(FW), .FIFO_DEPTH(DEPTH), .ROWS(2), .COLS(2), .R(0), .C(0)) u_dut (
        .clk(clk), .rst(rst),
        .flit_in_flat(a_fin), .valid_in_flat(a_vin), .ready_out_flat(a_rdy),
        .flit_out_flat(a_fout), .valid_out_flat(a_vout), .ready_in_flat(a_rin)
`ifdef ROUTER_STATS_EN
        , .drop_cnt(a_drop), .fwd_cnt_flat(a_fwd)
`endif
    );

    mesh_router_xy #(.FLIT_W(FW), .FIFO_DEPTH(DEPTH), .ROWS(3), .COLS(3), .R(1), .C(1)) u_ctr (
        .clk(clk), .rst(rst),
        .flit_in_flat(b_fin), .valid_in_flat(b_vin), .ready_out_flat(b_rdy),
        .flit_out_flat(b_fout), .valid_out_flat(b_vout), .ready_in_flat(b_rin)
`ifdef ROUTER_STATS_EN
        , .drop_cnt(b_drop), .fwd_cnt_flat(b_fwd)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Header {row, col} at the top, source port in [11:9], sequence in [8:0].
    function automatic logic [FW-1:0] mk(input int rw, input int cw, input int row,
                                         input int col, input int src, input int seq);
        logic [FW-1:0] f;
        f       = '0;
        f[8:0]  = 9'(seq);
        f[11:9] = 3'(src);
        f       = f | (FW'(row) << (FW - rw)) | (FW'(col) << (FW - rw - cw));
        return f;
    endfunction

    // Expected output of the 2x2 corner cell, -1 when the flit must be dropped.
    function automatic int ref_out(input int row, input int col, input int in_port);
        int o;
        if (row >= 2 || col >= 2) return -1;
        if (col > 0)      o = 1;
        else if (row > 0) o = 2;
        else              o = 4;
        if (o == in_port && in_port != 4) return -1;
        return o;
    endfunction

    // Scoreboard for u_dut: one queue per (input, output) pair.
    logic [FW-1:0] sbq [25][$];
    logic [4:0]    hold_v;
    logic [FW-1:0] hold_f [5];
    int            exp_drops;
    int            exp_fwd [5];
    logic [FW-1:0] mf;
    int            ms, mo;

    function automatic int sb_total();
        int n;
        n = 0;
        for (int i = 0; i < 25; i++) n += sbq[i].size();
        return n;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 25; i++) sbq[i].delete();
            hold_v    = '0;
            exp_drops = 0;
            for (int o = 0; o < 5; o++) exp_fwd[o] = 0;
        end else begin
            chk("offmesh_ready", {75'd0, a_rdy & 5'b01001}, 80'd0);
            chk("offmesh_valid", {75'd0, a_vout & 5'b01001}, 80'd0);
            for (int o = 0; o < 5; o++) begin
                mf = a_fout[o*FW +: FW];
                if (hold_v[o]) begin
                    chk("hold_valid", {79'd0, a_vout[o]}, 80'd1);
                    chk("hold_flit", {64'd0, mf}, {64'd0, hold_f[o]});
                end
                if (a_vout[o] && a_rin[o]) begin
                    exp_fwd[o]++;
                    ms = int'(mf[11:9]);
                    chk("src_range", {79'd0, ms < 5}, 80'd1);
                    if (ms < 5) begin
                        chk("sb_pending", {79'd0, sbq[ms*5+o].size() != 0}, 80'd1);
                        if (sbq[ms*5+o].size() != 0) begin
                            chk("sb_order", {64'd0, mf}, {64'd0, sbq[ms*5+o][0]});
                            void'(sbq[ms*5+o].pop_front());
                        end
                    end
                end
                hold_v[o] = a_vout[o] && !a_rin[o];
                hold_f[o] = mf;
            end
            for (int p = 0; p < 5; p++) begin
                if (a_vin[p] && a_rdy[p]) begin
                    mf = a_fin[p*FW +: FW];
                    mo = ref_out(int'(mf[15]), int'(mf[14]), p);
                    if (mo < 0) exp_drops++;
                    else sbq[p*5+mo].push_back(mf);
                end
            end
        end
    end

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb_total() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_empty", 80'(sb_total()), 80'd0);
        repeat (8) tick();
    endtask

    logic [FW-1:0] f;
    logic [4:0]    seen, pend;
    int            seq, last, pick;

    initial begin
        rst = 1'b1; seq = 0;
        a_vin = '0; a_fin = '0; a_rin = '1;
        b_vin = '0; b_fin = '0; b_rin = '1;
        tick(); tick();
        chk("rst_valid", {75'd0, a_vout}, 80'd0);
        chk("rst_ready", {75'd0, a_rdy}, 80'd0);
        chk("rst_flit", a_fout, 80'd0);
        rst = 1'b0;
        #1;
        chk("ready_before_edge", {75'd0, a_rdy}, 80'd0);
        tick();
        chk("ready_after_edge", {75'd0, a_rdy}, 80'b10110);

        // Local flit to (1,1) leaves on E one cycle after acceptance.
        f = mk(1, 1, 1, 1, 4, 1);
        a_fin[4*FW +: FW] = f; a_vin[4] = 1'b1;
        tick();
        a_vin = '0;
        chk("lat_before", {75'd0, a_vout}, 80'd0);
        tick();
        chk("lat_valid", {75'd0, a_vout}, 80'b00010);
        chk("lat_flit", {64'd0, a_fout[FW +: FW]}, {64'd0, f});
        tick();
        chk("lat_gone", {75'd0, a_vout}, 80'd0);

        // Backpressure on E: FIFO plus output stage absorb DEPTH+1 flits.
        a_rin[1] = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            chk("bp_ready", {79'd0, a_rdy[4]}, 80'd1);
            a_fin[4*FW +: FW] = mk(1, 1, 0, 1, 4, 10 + i); a_vin[4] = 1'b1;
            tick();
        end
        a_vin = '0;
        chk("bp_full", {79'd0, a_rdy[4]}, 80'd0);
        repeat (3) tick();
        chk("bp_valid", {79'd0, a_vout[1]}, 80'd1);
        chk("bp_head", {64'd0, a_fout[FW +: FW]}, {64'd0, mk(1, 1, 0, 1, 4, 10)});
        a_rin[1] = 1'b1;
        drain(40);

        // Valid on off-mesh N and W ports must be ignored.
        a_fin[0*FW +: FW] = mk(1, 1, 0, 0, 0, 50);
        a_fin[3*FW +: FW] = mk(1, 1, 0, 0, 3, 51);
        a_vin = 5'b01001;
        tick();
        a_vin = '0;
        seen = '0;
        repeat (4) begin tick(); seen |= a_vout; end
        chk("offmesh_ignored", {75'd0, seen}, 80'd0);

        // E input heading back east is a U-turn and gets dropped.
        a_fin[1*FW +: FW] = mk(1, 1, 0, 1, 1, 60); a_vin[1] = 1'b1;
        tick();
        a_vin = '0;
        seen = '0;
        repeat (4) begin tick(); seen |= a_vout; end
        chk("uturn_drop", {75'd0, seen}, 80'd0);
`ifdef ROUTER_STATS_EN
        chk("uturn_drop_cnt", {64'd0, a_drop}, 80'd1);
`endif

        // Randomised traffic against the scoreboard.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 5; p++) begin
                a_fin[p*FW +: FW] = mk(1, 1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), p, seq);
                seq++;
            end
            a_vin = 5'($urandom);
            a_rin = 5'($urandom) | 5'($urandom);
            tick();
        end
        a_vin = '0; a_rin = '1;
        drain(80);
`ifdef ROUTER_STATS_EN
        chk("rand_drop_cnt", {64'd0, a_drop}, 80'(exp_drops));
        for (int o = 0; o < 5; o++) chk("rand_fwd_cnt", {48'd0, a_fwd[o*32 +: 32]}, 80'(exp_fwd[o]));
`endif

        // Reset with three flits buffered discards them.
        a_rin[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_fin[4*FW +: FW] = mk(1, 1, 0, 1, 4, 70 + i); a_vin[4] = 1'b1;
            tick();
        end
        a_vin = '0;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_valid", {75'd0, a_vout}, 80'd0);
        chk("midrst_ready", {75'd0, a_rdy}, 80'd0);
        chk("midrst_flit", a_fout, 80'd0);
        tick();
        rst = 1'b0; a_rin = '1;
        seen = '0;
        repeat (8) begin tick(); seen |= a_vout; end
        chk("no_stale", {75'd0, seen}, 80'd0);

        // Centre cell: S, W, L all target E; grants rotate from one past pointer 0.
        b_fin[2*FW +: FW] = mk(2, 2, 1, 2, 2, 1);
        b_fin[3*FW +: FW] = mk(2, 2, 1, 2, 3, 2);
        b_fin[4*FW +: FW] = mk(2, 2, 1, 2, 4, 3);
        b_vin = 5'b11100;
        tick();
        b_vin = '0;
        pend = 5'b11100; last = 0;
        for (int g = 0; g < 3; g++) begin
            pick = -1;
            for (int k = 1; k <= 5; k++) begin
                if (pick < 0 && pend[(last + k) % 5]) pick = (last + k) % 5;
            end
            pend[pick] = 1'b0; last = pick;
            tick();
            chk("rr_valid", {75'd0, b_vout}, 80'b00010);
            chk("rr_src", {77'd0, b_fout[FW + 11 -: 3]}, 80'(pick));
        end
        tick();
        chk("rr_done", {75'd0, b_vout}, 80'd0);

        // Destination row 3 lies outside a 3-row mesh.
        b_fin[4*FW +: FW] = mk(2, 2, 3, 0, 4, 9); b_vin[4] = 1'b1;
        tick();
        b_vin = '0;
        seen = '0;
        repeat (4) begin tick(); seen |= b_vout; end
        chk("range_drop", {75'd0, seen}, 80'd0);
`ifdef ROUTER_STATS_EN
        chk("range_drop_cnt", {64'd0, b_drop}, 80'd1);
        chk("rr_fwd_cnt", {48'd0, b_fwd[32 +: 32]}, 80'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
